// File: rtl/msf_time_tracker.sv
// MSF time/date frame tracker: validates each 60 s frame, locks after a run of
// consistent minutes, and free-runs the time/date for a bounded holdover on loss.
module msf_time_tracker #(
    parameter int CONFIRM_FRAMES   = 2,
    parameter int HOLDOVER_MINUTES = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bits_valid_i,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    output logic [3:0] year_h_o,
    output logic [3:0] year_l_o,
    output logic       month_h_o,
    output logic [3:0] month_l_o,
    output logic [1:0] day_h_o,
    output logic [3:0] day_l_o,
    output logic [2:0] dow_o,
    output logic [1:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [2:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic       bst_o,
    output logic       bst_warn_o,
    output logic       valid_o,
    output logic       locked_o,
    output logic       holdover_o
);
    typedef struct packed {
        logic [3:0] yh;
        logic [3:0] yl;
        logic       mh;
        logic [3:0] ml;
        logic [1:0] dh;
        logic [3:0] dl;
        logic [2:0] dow;
        logic [1:0] hh;
        logic [3:0] hl;
        logic [2:0] nh;
        logic [3:0] nl;
    } msf_time_t;

    typedef enum logic [1:0] {UNLOCKED, CONFIRMING, LOCKED, HOLDOVER} state_t;

    // One spare count bit so cnt+1 never wraps, even with CONFIRM_FRAMES=1
    localparam int CW = $clog2(CONFIRM_FRAMES + 2);
    localparam int HW = $clog2(HOLDOVER_MINUTES + 2);

    function automatic logic [4:0] month_len(input msf_time_t t);
        logic [7:0] y;
        logic [4:0] m;
        y = 8'(t.yh) * 8'd10 + 8'(t.yl);
        m = t.mh ? 5'(t.ml) + 5'd10 : 5'(t.ml);
        case (m)
            5'd2:                       month_len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            5'd4, 5'd6, 5'd9, 5'd11:    month_len = 5'd30;
            default:                    month_len = 5'd31;
        endcase
    endfunction

    function automatic msf_time_t inc_time(input msf_time_t t);
        msf_time_t r;
        logic [5:0] d;
        r = t;
        d = 6'(t.dh) * 6'd10 + 6'(t.dl);
        if (t.nl != 4'd9) r.nl = t.nl + 4'd1;
        else begin
            r.nl = 4'd0;
            if (t.nh != 3'd5) r.nh = t.nh + 3'd1;
            else begin
                r.nh = 3'd0;
                if (!(t.hh == 2'd2 && t.hl == 4'd3)) begin
                    if (t.hl == 4'd9) begin r.hl = 4'd0; r.hh = t.hh + 2'd1; end
                    else r.hl = t.hl + 4'd1;
                end else begin
                    r.hh  = 2'd0;
                    r.hl  = 4'd0;
                    r.dow = (t.dow == 3'd6) ? 3'd0 : t.dow + 3'd1;
                    if (d < 6'(month_len(t))) begin
                        if (t.dl == 4'd9) begin r.dl = 4'd0; r.dh = t.dh + 2'd1; end
                        else r.dl = t.dl + 4'd1;
                    end else begin
                        r.dh = 2'd0;
                        r.dl = 4'd1;
                        if (!(t.mh && t.ml == 4'd2)) begin
                            if (t.ml == 4'd9) begin r.ml = 4'd0; r.mh = 1'b1; end
                            else r.ml = t.ml + 4'd1;
                        end else begin
                            r.mh = 1'b0;
                            r.ml = 4'd1;
                            if (t.yh == 4'd9 && t.yl == 4'd9) begin r.yh = 4'd0; r.yl = 4'd0; end
                            else if (t.yl == 4'd9) begin r.yl = 4'd0; r.yh = t.yh + 4'd1; end
                            else r.yl = t.yl + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    logic [59:0] sh_a, sh_b, rev;
    msf_time_t   dec, cand, cur;
    state_t      state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;

    // Bit-reversing A turns every MSB-first field into a plain slice
    assign rev = {<<{sh_a}};
    assign dec = msf_time_t'(rev[42:8]);

    logic [4:0] mon_bin;
    logic [5:0] day_bin, hour_bin;
    logic [6:0] min_bin;
    logic       marker_ok, parity_ok, range_ok, good, frame, match_cand, match_cur;

    assign mon_bin  = dec.mh ? 5'(dec.ml) + 5'd10 : 5'(dec.ml);
    assign day_bin  = 6'(dec.dh) * 6'd10 + 6'(dec.dl);
    assign hour_bin = 6'(dec.hh) * 6'd10 + 6'(dec.hl);
    assign min_bin  = 7'(dec.nh) * 7'd10 + 7'(dec.nl);

    assign marker_ok = (rev[7:0] == 8'b0111_1110);
    assign parity_ok = (sh_b[54] ^ (^sh_a[24:17])) & (sh_b[55] ^ (^sh_a[35:25])) &
                       (sh_b[56] ^ (^sh_a[38:36])) & (sh_b[57] ^ (^sh_a[51:39]));
    assign range_ok  = dec.yh <= 4'd9 && dec.yl <= 4'd9 && dec.ml <= 4'd9 && dec.dl <= 4'd9 &&
                       dec.hl <= 4'd9 && dec.nl <= 4'd9 &&
                       mon_bin >= 5'd1 && mon_bin <= 5'd12 &&
                       day_bin >= 6'd1 && day_bin <= {1'b0, month_len(dec)} &&
                       dec.dow <= 3'd6 && hour_bin <= 6'd23 && min_bin <= 7'd59;
    assign good       = marker_ok & parity_ok & range_ok;
    assign frame      = bits_valid_i & bits_is_second_00_i;
    assign match_cand = (dec == inc_time(cand));
    assign match_cur  = (dec == inc_time(cur));

    logic unused_bits;
    assign unused_bits = ^{rev[59:43], sh_b[59], sh_b[52:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_a       <= '0;
            sh_b       <= '0;
            cand       <= '0;
            cur        <= '0;
            cnt        <= '0;
            hcnt       <= '0;
            state      <= UNLOCKED;
            bst_o      <= 1'b0;
            bst_warn_o <= 1'b0;
            valid_o    <= 1'b0;
            locked_o   <= 1'b0;
            holdover_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (bits_valid_i) begin
                sh_a <= {bits_data_i[0], sh_a[59:1]};
                sh_b <= {bits_data_i[1], sh_b[59:1]};
            end
            if (frame) begin
                case (state)
                    UNLOCKED: if (good) begin
                        cand <= dec;
                        cnt  <= CW'(1);
                        if (CONFIRM_FRAMES == 1) begin
                            state <= LOCKED; locked_o <= 1'b1;
                            cur <= dec; bst_o <= sh_b[58]; bst_warn_o <= sh_b[53]; valid_o <= 1'b1;
                        end else state <= CONFIRMING;
                    end
                    CONFIRMING: if (!good) state <= UNLOCKED;
                    else begin
                        cand <= dec;
                        if (!match_cand) cnt <= CW'(1);
                        else begin
                            cnt <= cnt + CW'(1);
                            if (cnt + CW'(1) >= CW'(CONFIRM_FRAMES)) begin
                                state <= LOCKED; locked_o <= 1'b1;
                                cur <= dec; bst_o <= sh_b[58]; bst_warn_o <= sh_b[53]; valid_o <= 1'b1;
                            end
                        end
                    end
                    LOCKED, HOLDOVER: if (good && match_cur) begin
                        state <= LOCKED; holdover_o <= 1'b0;
                        cur <= dec; bst_o <= sh_b[58]; bst_warn_o <= sh_b[53]; valid_o <= 1'b1;
                    end else if (good) begin
                        state <= CONFIRMING; locked_o <= 1'b0; holdover_o <= 1'b0;
                        cand <= dec; cnt <= CW'(1);
                    end else if (HOLDOVER_MINUTES > 0 &&
                                 (state == LOCKED || hcnt < HW'(HOLDOVER_MINUTES))) begin
                        // Free-run one minute; BST flags keep their last decoded value
                        cur <= inc_time(cur); valid_o <= 1'b1;
                        hcnt <= (state == LOCKED) ? HW'(1) : hcnt + HW'(1);
                        state <= HOLDOVER; holdover_o <= 1'b1;
                    end else begin
                        state <= UNLOCKED; locked_o <= 1'b0; holdover_o <= 1'b0;
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

    assign {year_h_o, year_l_o}     = {cur.yh, cur.yl};
    assign {month_h_o, month_l_o}   = {cur.mh, cur.ml};
    assign {day_h_o, day_l_o}       = {cur.dh, cur.dl};
    assign dow_o                    = cur.dow;
    assign {hour_h_o, hour_l_o}     = {cur.hh, cur.hl};
    assign {minute_h_o, minute_l_o} = {cur.nh, cur.nl};
endmodule

// File: tb/tb_msf_time_tracker.sv
// Directed bench for msf_time_tracker: encodes MSF frames, feeds them second by
// second and compares outputs against hand-computed time/date values.
module tb_msf_time_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bits_valid = 1'b0, bits_s00 = 1'b0;
    logic [1:0] bits_data = 2'b00;
    logic [3:0] year_h, year_l, month_l, day_l, hour_l, minute_l;
    logic       month_h, bst, bst_warn, valid, locked, holdover;
    logic [1:0] day_h, hour_h;
    logic [2:0] dow, minute_h;

    int n_cmp = 0, n_bad = 0, pulses = 0, p0;

    msf_time_tracker #(.CONFIRM_FRAMES(2), .HOLDOVER_MINUTES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bits_valid_i(bits_valid),
        .bits_is_second_00_i(bits_s00), .bits_data_i(bits_data),
        .year_h_o(year_h), .year_l_o(year_l), .month_h_o(month_h), .month_l_o(month_l),
        .day_h_o(day_h), .day_l_o(day_l), .dow_o(dow), .hour_h_o(hour_h), .hour_l_o(hour_l),
        .minute_h_o(minute_h), .minute_l_o(minute_l), .bst_o(bst), .bst_warn_o(bst_warn),
        .valid_o(valid), .locked_o(locked), .holdover_o(holdover)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (valid) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    function automatic logic [59:0] put(input logic [59:0] v, input int start, input int width,
                                        input logic [7:0] val);
        for (int i = 0; i < width; i++) v[start + i] = val[width - 1 - i];
        return v;
    endfunction

    function automatic logic [34:0] exp_t(input int yy, mo, dd, dw, hh, mm);
        logic [7:0] y, m, d, h, n;
        logic [2:0] w;
        y = bcd(yy); m = bcd(mo); d = bcd(dd); h = bcd(hh); n = bcd(mm); w = 3'(dw);
        return {y, m[4:0], d[5:0], w, h[5:0], n[6:0]};
    endfunction

    function automatic logic [34:0] obs_t();
        return {year_h, year_l, month_h, month_l, day_h, day_l, dow, hour_h, hour_l, minute_h, minute_l};
    endfunction

    // corrupt: 0 none, 1 marker bit A59 set, 2 B55 parity flipped
    task automatic send(input int yy, mo, dd, dw, hh, mm, input logic b58, b53, input int corrupt);
        logic [59:0] a, b;
        a = '0; b = '0;
        a = put(a, 17, 8, bcd(yy));
        a = put(a, 25, 5, bcd(mo));
        a = put(a, 30, 6, bcd(dd));
        a = put(a, 36, 3, 8'(dw));
        a = put(a, 39, 6, bcd(hh));
        a = put(a, 45, 7, bcd(mm));
        a = put(a, 52, 8, 8'h7E);
        b[54] = ~^a[24:17]; b[55] = ~^a[35:25]; b[56] = ~^a[38:36]; b[57] = ~^a[51:39];
        b[58] = b58; b[53] = b53;
        if (corrupt == 1) a[59] = 1'b1;
        if (corrupt == 2) b[55] = ~b[55];
        p0 = pulses;
        for (int k = 0; k < 60; k++) begin
            if (k == 30) begin
                @(negedge clk); bits_valid = 1'b0; bits_s00 = 1'b1;
            end
            @(negedge clk); bits_valid = 1'b1; bits_s00 = 1'b0; bits_data = {b[k], a[k]};
        end
        @(negedge clk); bits_valid = 1'b1; bits_s00 = 1'b1; bits_data = 2'b00;
        @(negedge clk); bits_valid = 1'b0; bits_s00 = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_st(input string tag, input logic [34:0] t, input logic lk, ho, input int np);
        chk({tag, "_time"}, 64'(obs_t()), 64'(t));
        chk({tag, "_flags"}, {62'd0, locked, holdover}, {62'd0, lk, ho});
        chk({tag, "_pulses"}, 64'(pulses - p0), 64'(np));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_time", 64'(obs_t()), 64'd0);
        chk("rst_flags", {59'd0, valid, locked, holdover, bst, bst_warn}, 64'd0);
        rst_n = 1'b1;

        send(23, 6, 14, 3, 10, 41, 1'b1, 1'b0, 0);
        expect_st("first", 35'd0, 1'b0, 1'b0, 0);
        send(23, 6, 14, 3, 10, 42, 1'b1, 1'b0, 0);
        expect_st("lock", exp_t(23, 6, 14, 3, 10, 42), 1'b1, 1'b0, 1);
        chk("lock_bst", {62'd0, bst, bst_warn}, 64'b10);

        send(23, 6, 14, 3, 11, 30, 1'b0, 1'b1, 0);
        expect_st("jump", exp_t(23, 6, 14, 3, 10, 42), 1'b0, 1'b0, 0);
        send(23, 6, 14, 3, 11, 31, 1'b0, 1'b1, 0);
        expect_st("relock", exp_t(23, 6, 14, 3, 11, 31), 1'b1, 1'b0, 1);
        chk("relock_bst", {62'd0, bst, bst_warn}, 64'b01);

        send(23, 6, 14, 3, 5, 5, 1'b1, 1'b0, 2);
        expect_st("par55", exp_t(23, 6, 14, 3, 11, 32), 1'b1, 1'b1, 1);
        chk("hold_bst", {62'd0, bst, bst_warn}, 64'b01);
        send(23, 13, 1, 3, 0, 0, 1'b1, 1'b0, 0);
        expect_st("mon13", exp_t(23, 6, 14, 3, 11, 33), 1'b1, 1'b1, 1);
        send(23, 6, 14, 3, 11, 34, 1'b0, 1'b0, 1);
        expect_st("hexp", exp_t(23, 6, 14, 3, 11, 33), 1'b0, 1'b0, 0);

        send(23, 12, 31, 0, 23, 57, 1'b0, 1'b0, 0);
        send(23, 12, 31, 0, 23, 58, 1'b0, 1'b0, 0);
        expect_st("dec58", exp_t(23, 12, 31, 0, 23, 58), 1'b1, 1'b0, 1);
        send(23, 12, 31, 0, 23, 59, 1'b0, 1'b0, 0);
        expect_st("dec59", exp_t(23, 12, 31, 0, 23, 59), 1'b1, 1'b0, 1);
        send(23, 12, 31, 0, 23, 59, 1'b0, 1'b0, 1);
        expect_st("newyear", exp_t(24, 1, 1, 1, 0, 0), 1'b1, 1'b1, 1);

        send(24, 2, 28, 3, 23, 58, 1'b0, 1'b0, 0);
        expect_st("feb_cand", exp_t(24, 1, 1, 1, 0, 0), 1'b0, 1'b0, 0);
        send(24, 2, 28, 3, 23, 59, 1'b0, 1'b0, 0);
        send(24, 2, 28, 3, 0, 0, 1'b0, 1'b0, 1);
        expect_st("leap", exp_t(24, 2, 29, 4, 0, 0), 1'b1, 1'b1, 1);

        send(23, 2, 28, 2, 23, 58, 1'b0, 1'b0, 0);
        send(23, 2, 28, 2, 23, 59, 1'b0, 1'b0, 0);
        send(23, 2, 28, 2, 0, 0, 1'b0, 1'b0, 1);
        expect_st("noleap", exp_t(23, 3, 1, 3, 0, 0), 1'b1, 1'b1, 1);
        send(23, 3, 1, 3, 0, 1, 1'b0, 1'b0, 0);
        expect_st("recover", exp_t(23, 3, 1, 3, 0, 1), 1'b1, 1'b0, 1);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk); bits_valid = 1'b1; bits_data = 2'b01;
        end
        rst_n = 1'b0; bits_valid = 1'b0;
        @(negedge clk);
        chk("mrst_time", 64'(obs_t()), 64'd0);
        chk("mrst_flags", {59'd0, valid, locked, holdover, bst, bst_warn}, 64'd0);
        rst_n = 1'b1;
        send(23, 3, 1, 3, 0, 2, 1'b0, 1'b0, 0);
        expect_st("post_rst", 35'd0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
